// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART bridge: register offsets, bit indices
// and FSM state types.
package mmio_uart_pkg;

   localparam logic [1:0] OffData   = 2'd0;
   localparam logic [1:0] OffStatus = 2'd1;
   localparam logic [1:0] OffCtrl   = 2'd2;
   localparam logic [1:0] OffCount  = 2'd3;

   localparam int unsigned StTxFull   = 0;
   localparam int unsigned StTxEmpty  = 1;
   localparam int unsigned StRxEmpty  = 2;
   localparam int unsigned StRxFull   = 3;
   localparam int unsigned StTxDrop   = 4;
   localparam int unsigned StLoopback = 5;

   localparam int unsigned CtrlRxPop    = 0;
   localparam int unsigned CtrlDropClr  = 1;
   localparam int unsigned CtrlLoopback = 2;

   typedef enum logic [1:0] {TxIdle, TxStrobe, TxGap} tx_state_t;
   typedef enum logic [1:0] {RxIdle, RxAck, RxGap} rx_state_t;

endpackage

// File: rtl/mmio_uart_bridge_fifo.sv
// Synchronous byte FIFO with occupancy count; push when full and pop when empty are ignored.
module byte_fifo #(
   parameter int unsigned Depth = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               wdata,
   output logic [7:0]               rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(Depth):0]   count
);
   localparam int unsigned AddrW = $clog2(Depth);
   localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

   logic [7:0]       mem [Depth];
   logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AddrW:0]   count_q;
   logic             do_push, do_pop;

   assign full    = count_q == DepthCnt;
   assign empty   = count_q == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   // Pointers wrap naturally since Depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_bridge.sv
// MMIO responder bridging the CPU bus to byte-wide UART ports through TX/RX FIFOs.
// Optional loopback path is built when MMIO_UART_LOOPBACK_EN is defined.
module mmio_uart_bridge
   import mmio_uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR  = 16'hF000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        hwclk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        write_en,
   output logic [7:0]  rdata,
   output logic        hit,
   output logic [7:0]  txdata,
   output logic        txclk,
   input  logic        txready,
   input  logic [7:0]  rxdata,
   output logic        rxclk,
   input  logic        rxready
);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   logic            win, wr_data, wr_ctrl;
   logic [1:0]      off;
   logic            tx_push, tx_pop, tx_full, tx_empty;
   logic            rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]      tx_head, rx_head, rx_wdata, rd_mux;
   logic [CntW-1:0] tx_count, rx_count;
   logic            loopback, tx_go, rx_go;
   logic [7:0]      rdata_q, txdata_q;
   logic            hit_q, txclk_q, rxclk_q, tx_drop_q;
   tx_state_t       tx_state_q, tx_state_d;
   rx_state_t       rx_state_q, rx_state_d;

   assign win     = addr[15:2] == BASE_ADDR[15:2];
   assign off     = addr[1:0];
   assign wr_data = write_en && win && (off == OffData);
   assign wr_ctrl = write_en && win && (off == OffCtrl);

`ifdef MMIO_UART_LOOPBACK_EN
   logic loopback_q;
   always_ff @(posedge hwclk or posedge reset) begin
      if (reset)        loopback_q <= 1'b0;
      else if (wr_ctrl) loopback_q <= wdata[CtrlLoopback];
   end
   assign loopback = loopback_q;
`else
   assign loopback = 1'b0;
`endif

   assign tx_push  = wr_data && !tx_full;
   assign tx_pop   = tx_go;
   // In loopback the TX FSM is the only RX producer, so the two pushes never collide.
   assign rx_push  = rx_go || (tx_go && loopback);
   assign rx_wdata = rx_go ? rxdata : tx_head;
   assign rx_pop   = wr_ctrl && wdata[CtrlRxPop];

   byte_fifo #(.Depth(FIFO_DEPTH)) u_tx_fifo (
      .clk   (hwclk),
      .rst   (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (wdata),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   byte_fifo #(.Depth(FIFO_DEPTH)) u_rx_fifo (
      .clk   (hwclk),
      .rst   (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_wdata),
      .rdata (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_go      = 1'b0;
      unique case (tx_state_q)
         TxIdle: begin
            if (!tx_empty && (loopback ? !rx_full : txready)) begin
               tx_go      = 1'b1;
               tx_state_d = TxStrobe;
            end
         end
         TxStrobe: tx_state_d = TxGap;
         TxGap:    tx_state_d = TxIdle;
         default:  tx_state_d = TxIdle;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_go      = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (!loopback && rxready && !rx_full) begin
               rx_go      = 1'b1;
               rx_state_d = RxAck;
            end
         end
         RxAck:   rx_state_d = RxGap;
         RxGap:   rx_state_d = RxIdle;
         default: rx_state_d = RxIdle;
      endcase
   end

   always_comb begin
      rd_mux = 8'h00;
      unique case (off)
         OffData:   rd_mux = rx_empty ? 8'h00 : rx_head;
         OffStatus: begin
            rd_mux[StTxFull]   = tx_full;
            rd_mux[StTxEmpty]  = tx_empty;
            rd_mux[StRxEmpty]  = rx_empty;
            rd_mux[StRxFull]   = rx_full;
            rd_mux[StTxDrop]   = tx_drop_q;
            rd_mux[StLoopback] = loopback;
         end
         OffCtrl:   rd_mux[CtrlLoopback] = loopback;
         OffCount:  rd_mux = {4'(rx_count), 4'(tx_count)};
         default:   rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         tx_state_q <= TxIdle;
         rx_state_q <= RxIdle;
         rdata_q    <= 8'h00;
         hit_q      <= 1'b0;
         txdata_q   <= 8'h00;
         txclk_q    <= 1'b0;
         rxclk_q    <= 1'b0;
         tx_drop_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         rdata_q    <= win ? rd_mux : 8'h00;
         hit_q      <= win;
         txclk_q    <= tx_go && !loopback;
         rxclk_q    <= rx_go;
         if (tx_go) txdata_q <= tx_head;
         if (wr_ctrl && wdata[CtrlDropClr]) tx_drop_q <= 1'b0;
         else if (wr_data && tx_full)       tx_drop_q <= 1'b1;
      end
   end

   assign rdata  = rdata_q;
   assign hit    = hit_q;
   assign txdata = txdata_q;
   assign txclk  = txclk_q;
   assign rxclk  = rxclk_q;

endmodule
